// File: rtl/axil_sdram_bridge_if.sv
// AXI4-Lite channel bundle between an interconnect master and the SDRAM bridge.
// Ports (signals): AW (awaddr/awprot/awvalid/awready), W (wdata/wstrb/wvalid/wready),
// B (bresp/bvalid/bready), AR (araddr/arprot/arvalid/arready), R (rdata/rresp/rvalid/rready).
// The master modport drives requests; the slave modport drives readies and responses.
interface axil_sdram_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid,    input wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input rready
    );
endinterface

// File: rtl/axil_sdram_bridge.sv
// AXI4-Lite slave that splits each AXI word access into BEATS native-width
// commands on an SDRAM-controller host port. One transaction in flight; AW, W
// and AR each have a one-entry holding register so new requests can be
// accepted while the current one runs. Reads and writes are arbitrated
// round-robin when both are pending.
//
// Ports:
//   aclk, aresetn       clock; asynchronous active-low reset
//   s_axil              AXI4-Lite slave (axil_sdram_bridge_if.slave)
//   mem_addr            beat address in MEM_DATA_WIDTH units
//   mem_wdata/wmask     beat write data; wmask bit = 1 means byte not written
//   mem_wr_enable       one-cycle write command
//   mem_rd_enable       one-cycle read command
//   mem_rdata/rd_ready  read data and its one-cycle strobe
//   mem_busy            controller cannot take a command this cycle
//
// state    | meaning
// IDLE     | wait for a complete write (AW+W) or a read (AR), arbitrate
// WR_ISSUE | emit one write beat per cycle, skipping beats with no strobes
// RD_ISSUE | emit the read command for the current beat
// RD_WAIT  | wait for mem_rd_ready, capture the beat
// WR_RESP  | hold bvalid/bresp until bready
// RD_RESP  | hold rvalid/rdata/rresp until rready
module axil_sdram_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int MEM_DATA_WIDTH = 16,
    parameter int MEM_ADDR_WIDTH = 24
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    axil_sdram_bridge_if.slave          s_axil,
    output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
    output logic [MEM_DATA_WIDTH-1:0]   mem_wdata,
    output logic [MEM_DATA_WIDTH/8-1:0] mem_wmask,
    output logic                        mem_wr_enable,
    output logic                        mem_rd_enable,
    input  logic [MEM_DATA_WIDTH-1:0]   mem_rdata,
    input  logic                        mem_rd_ready,
    input  logic                        mem_busy
);

    localparam int BEATS      = DATA_WIDTH / MEM_DATA_WIDTH;
    localparam int MEM_STRB   = MEM_DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(MEM_STRB);
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ADDR_HI    = MEM_ADDR_WIDTH + BYTE_SHIFT;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        RD_ISSUE,
        RD_WAIT,
        WR_RESP,
        RD_RESP
    } state_t;

    state_t                state, state_next;
    logic [BEAT_W-1:0]     beat, beat_next;

    logic                  aw_full, aw_full_d, awready_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic                  w_full, w_full_d, wready_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;
    logic                  ar_full, ar_full_d, arready_q;
    logic [ADDR_WIDTH-1:0] ar_addr_q;

    logic                  prefer_wr;
    logic                  resp_err;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  aw_hs, w_hs, ar_hs;
    logic                  wr_grant, rd_grant, grant_err;
    logic                  wr_done, rd_done, rd_capture;
    logic                  wr_oor, rd_oor, last_beat;
    logic [MEM_DATA_WIDTH-1:0] cur_wdata;
    logic [MEM_STRB-1:0]   cur_strb;
    logic                  unused_prot;

    // Any address bit at or above the host-port byte span makes the access out of range.
    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        logic hit;
        hit = 1'b0;
        for (int i = ADDR_HI; i < ADDR_WIDTH; i++) begin
            hit = hit | a[i];
        end
        return hit;
    endfunction

    // Byte address -> beat address: drop the in-beat byte bits, align down to a
    // whole AXI word, then add the beat index.
    function automatic logic [MEM_ADDR_WIDTH-1:0] beat_addr(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [BEAT_W-1:0]     b
    );
        logic [ADDR_WIDTH-1:0] word;
        word = a >> BYTE_SHIFT;
        return (MEM_ADDR_WIDTH'(word) & ~MEM_ADDR_WIDTH'(BEATS - 1)) + MEM_ADDR_WIDTH'(b);
    endfunction

    assign aw_hs = s_axil.awvalid & awready_q;
    assign w_hs  = s_axil.wvalid  & wready_q;
    assign ar_hs = s_axil.arvalid & arready_q;

    assign s_axil.awready = awready_q;
    assign s_axil.wready  = wready_q;
    assign s_axil.arready = arready_q;
    assign s_axil.bresp   = (state == WR_RESP && resp_err) ? 2'b10 : 2'b00;
    assign s_axil.rresp   = (state == RD_RESP && resp_err) ? 2'b10 : 2'b00;
    assign s_axil.rdata   = rdata_q;

    assign cur_wdata = w_data_q[int'(beat)*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
    assign cur_strb  = w_strb_q[int'(beat)*MEM_STRB +: MEM_STRB];
    assign last_beat = (beat == LAST_BEAT);
    assign wr_oor    = out_of_range(aw_addr_q);
    assign rd_oor    = out_of_range(ar_addr_q);

    assign unused_prot = ^{s_axil.awprot, s_axil.arprot};

    // Holding-register occupancy. A clear only happens while the register is
    // full (ready low), so it can never collide with a load.
    always_comb begin
        aw_full_d = aw_full;
        w_full_d  = w_full;
        ar_full_d = ar_full;
        if (wr_done) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end else begin
            if (aw_hs) aw_full_d = 1'b1;
            if (w_hs)  w_full_d  = 1'b1;
        end
        if (rd_done)    ar_full_d = 1'b0;
        else if (ar_hs) ar_full_d = 1'b1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            ar_full   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            ar_addr_q <= '0;
            prefer_wr <= 1'b1;
            resp_err  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            aw_full   <= aw_full_d;
            w_full    <= w_full_d;
            ar_full   <= ar_full_d;
            awready_q <= ~aw_full_d;
            wready_q  <= ~w_full_d;
            arready_q <= ~ar_full_d;
            if (aw_hs) aw_addr_q <= s_axil.awaddr;
            if (w_hs) begin
                w_data_q <= s_axil.wdata;
                w_strb_q <= s_axil.wstrb;
            end
            if (ar_hs) ar_addr_q <= s_axil.araddr;

            if (wr_grant)      prefer_wr <= 1'b0;
            else if (rd_grant) prefer_wr <= 1'b1;

            if (wr_grant || rd_grant) resp_err <= grant_err;

            if (rd_grant && rd_oor) begin
                rdata_q <= '0;
            end else if (rd_capture) begin
                rdata_q[int'(beat)*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_next    = state;
        beat_next     = beat;
        wr_grant      = 1'b0;
        rd_grant      = 1'b0;
        grant_err     = 1'b0;
        wr_done       = 1'b0;
        rd_done       = 1'b0;
        rd_capture    = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wmask     = '0;
        mem_wr_enable = 1'b0;
        mem_rd_enable = 1'b0;
        s_axil.bvalid = 1'b0;
        s_axil.rvalid = 1'b0;

        case (state)
            IDLE: begin
                beat_next = '0;
                if (aw_full && w_full && (!ar_full || prefer_wr)) begin
                    wr_grant  = 1'b1;
                    grant_err = wr_oor;
                    if (wr_oor) begin
                        wr_done    = 1'b1;
                        state_next = WR_RESP;
                    end else begin
                        state_next = WR_ISSUE;
                    end
                end else if (ar_full) begin
                    rd_grant  = 1'b1;
                    grant_err = rd_oor;
                    if (rd_oor) begin
                        rd_done    = 1'b1;
                        state_next = RD_RESP;
                    end else begin
                        state_next = RD_ISSUE;
                    end
                end
            end

            WR_ISSUE: begin
                mem_addr  = beat_addr(aw_addr_q, beat);
                mem_wdata = cur_wdata;
                mem_wmask = ~cur_strb;
                // A beat with no strobes is skipped even while the controller is busy.
                if (cur_strb == '0 || !mem_busy) begin
                    mem_wr_enable = (cur_strb != '0);
                    if (last_beat) begin
                        wr_done    = 1'b1;
                        state_next = WR_RESP;
                    end else begin
                        beat_next = beat + 1'b1;
                    end
                end
            end

            RD_ISSUE: begin
                mem_addr = beat_addr(ar_addr_q, beat);
                if (!mem_busy) begin
                    mem_rd_enable = 1'b1;
                    state_next    = RD_WAIT;
                end
            end

            RD_WAIT: begin
                if (mem_rd_ready) begin
                    rd_capture = 1'b1;
                    if (last_beat) begin
                        rd_done    = 1'b1;
                        state_next = RD_RESP;
                    end else begin
                        beat_next  = beat + 1'b1;
                        state_next = RD_ISSUE;
                    end
                end
            end

            WR_RESP: begin
                s_axil.bvalid = 1'b1;
                if (s_axil.bready) state_next = IDLE;
            end

            RD_RESP: begin
                s_axil.rvalid = 1'b1;
                if (s_axil.rready) state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

endmodule
